// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, default-slave state type and select popcount
// helper for the response multiplexer.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ERR1 = 2'd1,
        D_ERR2 = 2'd2
    } dstate_e;

    typedef enum logic [1:0] {
        PC_ZERO = 2'd0,
        PC_ONE  = 2'd1,
        PC_MANY = 2'd2
    } popcnt_e;

    // Saturating popcount: only zero / exactly-one / more-than-one matters.
    function automatic popcnt_e sel_count(input logic [31:0] v);
        logic seen;
        logic many;
        seen = 1'b0;
        many = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                if (seen) many = 1'b1;
                seen = 1'b1;
            end
        end
        if (many) return PC_MANY;
        if (seen) return PC_ONE;
        return PC_ZERO;
    endfunction

endpackage

// File: rtl/muxn_onehot.sv
// Pure AND-OR multiplexer; sel is expected one-hot or zero, zero gives zero.
module muxn_onehot #(
    parameter int NS = 13,
    parameter int DW = 32
) (
    input  logic [NS-1:0]    sel,
    input  logic [NS*DW-1:0] data,
    output logic [DW-1:0]    out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < NS; i++) begin
            out = out | (data[i*DW +: DW] & {DW{sel[i]}});
        end
    end

endmodule

// File: rtl/ahb_resp_muxn.sv
// AHB-Lite slave-to-master response mux with registered data-phase select
// and a built-in default slave answering unmapped or multi-selected transfers.
module ahb_resp_muxn
    import ahb_pkg::*;
#(
    parameter int NS = 13,
    parameter int DW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NS-1:0]    hsel,
    input  logic [1:0]       htrans,
    input  logic [NS*DW-1:0] s_hrdata,
    input  logic [NS-1:0]    s_hreadyout,
    input  logic [NS-1:0]    s_hresp,
    output logic [DW-1:0]    hrdata,
    output logic             hready,
    output logic             hresp,
    output logic             sel_err
);

    // Handshake: an address phase is taken on every clk edge with hready = 1;
    // while hready = 0 the data phase in flight (dsel, default slave) holds.

    logic [NS-1:0] dsel;
    dstate_e       dstate;
    logic          def_ready;
    logic          def_resp;

    popcnt_e       sel_pc;
    logic          xfer_active;
    logic          def_claim;
    logic          mux_ready;
    logic          mux_resp;

    assign sel_pc      = sel_count(32'(hsel));
    assign xfer_active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign def_claim   = hready && xfer_active && (sel_pc != PC_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsel      <= '0;
            sel_err   <= 1'b0;
            dstate    <= D_IDLE;
            def_ready <= 1'b1;
            def_resp  <= HRESP_OKAY;
        end else begin
            sel_err <= hready && (sel_pc == PC_MANY);
            if (hready) begin
                dsel <= (sel_pc == PC_ONE) ? hsel : '0;
            end
            // Outputs are registered next to the state so they are glitch-free.
            case (dstate)
                D_IDLE: begin
                    if (def_claim) begin
                        dstate    <= D_ERR1;
                        def_ready <= 1'b0;
                        def_resp  <= HRESP_ERROR;
                    end
                end
                D_ERR1: begin
                    dstate    <= D_ERR2;
                    def_ready <= 1'b1;
                    def_resp  <= HRESP_ERROR;
                end
                D_ERR2: begin
                    if (def_claim) begin
                        dstate    <= D_ERR1;
                        def_ready <= 1'b0;
                        def_resp  <= HRESP_ERROR;
                    end else begin
                        dstate    <= D_IDLE;
                        def_ready <= 1'b1;
                        def_resp  <= HRESP_OKAY;
                    end
                end
                default: begin
                    dstate    <= D_IDLE;
                    def_ready <= 1'b1;
                    def_resp  <= HRESP_OKAY;
                end
            endcase
        end
    end

    muxn_onehot #(.NS(NS), .DW(DW)) u_mux_rdata (
        .sel  (dsel),
        .data (s_hrdata),
        .out  (hrdata)
    );

    muxn_onehot #(.NS(NS), .DW(1)) u_mux_ready (
        .sel  (dsel),
        .data (s_hreadyout),
        .out  (mux_ready)
    );

    muxn_onehot #(.NS(NS), .DW(1)) u_mux_resp (
        .sel  (dsel),
        .data (s_hresp),
        .out  (mux_resp)
    );

    // The default slave owns the bus whenever no real slave is selected.
    assign hready = (dsel == '0) ? def_ready : mux_ready;
    assign hresp  = (dsel == '0) ? def_resp  : mux_resp;

endmodule
